ws2812_frame_parser: RTL and testbench

Framed-command parser between the UART receiver and the pixel write FIFO of the WS2812 PHY. It consumes received bytes and validates a sync/command/length/checksum frame. Pixel payload bytes go straight into the FIFO, and the runtime `num_leds` register is owned here. It replaces the raw byte-to-FIFO path so that a corrupted or partial serial stream resynchronises on the next frame instead of shifting colour data permanently.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_rx_timeout.sv | 37 +++
 rtl/ws2812_frame_parser.sv | 194 +++++++++++++++++++
 tb/tb_ws2812_frame_parser.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 framed-command parser.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CSUM
  } state_e;

  localparam logic [7:0] CMD_PIXEL     = 8'h01;
  localparam logic [7:0] CMD_CONFIG    = 8'h02;

  localparam logic [1:0] ERR_CSUM      = 2'd0;
  localparam logic [1:0] ERR_HDR       = 2'd1;
  localparam logic [1:0] ERR_OVF       = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Pixel payload length in bytes: 3*n via shift-and-add.
  function automatic logic [13:0] times3(input logic [11:0] n);
    return {2'b00, n} + {1'b0, n, 1'b0};
  endfunction

endpackage

// File: rtl/ws2812_rx_timeout.sv
// Inter-byte timeout: counter cleared by clr or while disabled, pulses tc at terminal count.
module ws2812_rx_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned    CW   = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != TERM) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte in the terminal cycle wins over the timeout.
  assign tc = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/ws2812_frame_parser.sv
// Validates SYNC/CMD/LEN/payload/CSUM frames from the UART, forwards pixel bytes
// to the write FIFO and owns the runtime num_leds register.
module ws2812_frame_parser
  import ws2812_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter logic [11:0] NUM_LEDS_RST = 12'd88,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wdata,
  output logic [11:0] num_leds,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  state_e state_q, state_d;

  logic        is_cfg_q, is_cfg_d;
  logic [7:0]  len_h_q, len_h_d;
  logic [7:0]  csum_q, csum_d;
  logic [13:0] pay_cnt_q, pay_cnt_d;
  logic [11:0] cfg_leds_q, cfg_leds_d;
  logic [11:0] num_leds_q, num_leds_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;

  logic [15:0] len;
  logic        cmd_ok, pix_len_ok, cfg_len_ok, len_ok;
  logic        timeout_tc;

  assign len        = {len_h_q, rx_byte};
  assign cmd_ok     = (rx_byte == CMD_PIXEL) || (rx_byte == CMD_CONFIG);
  assign pix_len_ok = (len != '0) && (len <= {4'h0, num_leds_q});
  assign cfg_len_ok = (len != '0) && (len[15:12] == 4'h0);
  assign len_ok     = is_cfg_q ? cfg_len_ok : pix_len_ok;

  ws2812_rx_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .en  (state_q != ST_IDLE),
    .clr (rx_dv),
    .tc  (timeout_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_dv) begin
      case (state_q)
        ST_IDLE:    if (rx_byte == SYNC_BYTE) state_d = ST_CMD;
        ST_CMD:     state_d = cmd_ok ? ST_LEN_H : ST_IDLE;
        ST_LEN_H:   state_d = ST_LEN_L;
        ST_LEN_L: begin
          if (!len_ok)       state_d = ST_IDLE;
          else if (is_cfg_q) state_d = ST_CSUM;
          else               state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (fifo_full)              state_d = ST_IDLE;
          else if (pay_cnt_q == 14'd1) state_d = ST_CSUM;
        end
        ST_CSUM:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (timeout_tc) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    is_cfg_d   = is_cfg_q;
    len_h_d    = len_h_q;
    csum_d     = csum_q;
    pay_cnt_d  = pay_cnt_q;
    cfg_leds_d = cfg_leds_q;
    num_leds_d = num_leds_q;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    if (rx_dv) begin
      case (state_q)
        ST_CMD: begin
          if (cmd_ok) begin
            is_cfg_d = (rx_byte == CMD_CONFIG);
            csum_d   = rx_byte;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end
        end
        ST_LEN_H: begin
          len_h_d = rx_byte;
          csum_d  = csum_q ^ rx_byte;
        end
        ST_LEN_L: begin
          csum_d     = csum_q ^ rx_byte;
          cfg_leds_d = len[11:0];
          pay_cnt_d  = times3(len[11:0]);
          if (!len_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end
        end
        ST_PAYLOAD: begin
          if (fifo_full) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
          end else begin
            wr_en_d   = 1'b1;
            wdata_d   = rx_byte;
            csum_d    = csum_q ^ rx_byte;
            pay_cnt_d = pay_cnt_q - 14'd1;
          end
        end
        ST_CSUM: begin
          if (rx_byte == csum_q) begin
            done_d = 1'b1;
            if (is_cfg_q) num_leds_d = cfg_leds_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end else if (timeout_tc) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_cfg_q   <= 1'b0;
      len_h_q    <= '0;
      csum_q     <= '0;
      pay_cnt_q  <= '0;
      cfg_leds_q <= '0;
      num_leds_q <= NUM_LEDS_RST;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      is_cfg_q   <= is_cfg_d;
      len_h_q    <= len_h_d;
      csum_q     <= csum_d;
      pay_cnt_q  <= pay_cnt_d;
      cfg_leds_q <= cfg_leds_d;
      num_leds_q <= num_leds_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_wdata = wdata_q;
  assign num_leds   = num_leds_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ws2812_frame_parser.sv
// Self-checking bench for ws2812_frame_parser: directed frames plus random streams
// checked against a frame-level reference model.
module tb_ws2812_frame_parser;

  localparam int unsigned TO   = 300;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic [11:0] num_leds;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  ws2812_frame_parser #(
    .SYNC_BYTE    (SYNC),
    .NUM_LEDS_RST (12'd88),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .num_leds   (num_leds),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic [7:0]  stim[$];
  logic [7:0]  got_wr[$];
  int          got_ev[$];   // 4 = frame_done, 0..3 = frame_err code
  logic [11:0] got_nl[$];
  logic [7:0]  exp_wr[$];
  int          exp_ev[$];
  logic [11:0] exp_nl[$];
  logic [11:0] model_nl = 12'd88;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en) got_wr.push_back(fifo_wdata);
      if (frame_done) begin
        got_ev.push_back(4);
        got_nl.push_back(num_leds);
      end
      if (frame_err) got_ev.push_back(int'(err_code));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_wr.delete(); got_ev.delete(); got_nl.delete();
  endtask

  // Called at a negedge; returns at a negedge. gap = idle cycles after the strobe.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    rx_byte = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stim(input int gapmax);
    foreach (stim[i]) send_byte(stim[i], (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0)));
  endtask

  // Reference: scans the stream frame by frame using array indexing and plain arithmetic.
  function automatic void model_stream();
    int i = 0;
    int n;
    logic [7:0]  cmd, x;
    logic [15:0] len;
    bit ok;
    exp_wr.delete(); exp_ev.delete(); exp_nl.delete();
    while (i < stim.size()) begin
      if (stim[i] != SYNC) begin i++; continue; end
      cmd = stim[i+1];
      if (cmd != 8'h01 && cmd != 8'h02) begin exp_ev.push_back(1); i += 2; continue; end
      len = {stim[i+2], stim[i+3]};
      if (cmd == 8'h01) ok = (len >= 1) && (int'(len) <= int'(model_nl));
      else              ok = (len >= 1) && (len <= 16'd4095);
      if (!ok) begin exp_ev.push_back(1); i += 4; continue; end
      n = (cmd == 8'h01) ? 3 * int'(len) : 0;
      x = 8'h00;
      for (int k = 1; k <= 3 + n; k++) x ^= stim[i+k];
      for (int k = 0; k < n; k++) exp_wr.push_back(stim[i+4+k]);
      if (stim[i+4+n] == x) begin
        exp_ev.push_back(4);
        if (cmd == 8'h02) model_nl = len[11:0];
        exp_nl.push_back(model_nl);
      end else begin
        exp_ev.push_back(0);
      end
      i += 5 + n;
    end
  endfunction

  task automatic gen_frame();
    int kind = int'($urandom_range(7, 0));
    logic [15:0] len;
    logic [7:0]  x, b;
    case (kind)
      0, 1: begin
        len = 16'($urandom_range(4, 1));
        stim.push_back(SYNC); stim.push_back(8'h01);
        stim.push_back(len[15:8]); stim.push_back(len[7:0]);
        x = 8'h01 ^ len[15:8] ^ len[7:0];
        for (int k = 0; k < 3 * int'(len); k++) begin
          b = ($urandom_range(3, 0) == 0) ? SYNC : 8'($urandom);
          stim.push_back(b);
          x ^= b;
        end
        stim.push_back(kind == 0 ? x : x ^ 8'h5A);
      end
      2, 3: begin
        len = 16'($urandom_range(40, 4));
        stim.push_back(SYNC); stim.push_back(8'h02);
        stim.push_back(len[15:8]); stim.push_back(len[7:0]);
        x = 8'h02 ^ len[15:8] ^ len[7:0];
        stim.push_back(kind == 2 ? x : x ^ 8'h01);
      end
      4: begin
        stim.push_back(SYNC); stim.push_back(8'($urandom_range(255, 3)));
      end
      5: begin
        len = ($urandom_range(1, 0) == 0) ? 16'h0000 : (16'h1000 | 16'($urandom));
        stim.push_back(SYNC); stim.push_back(8'h01);
        stim.push_back(len[15:8]); stim.push_back(len[7:0]);
      end
      6: begin
        for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
          b = 8'($urandom);
          stim.push_back(b == SYNC ? 8'h00 : b);
        end
      end
      default: begin
        len = 16'h1000 | 16'($urandom);
        stim.push_back(SYNC); stim.push_back(8'h02);
        stim.push_back(len[15:8]); stim.push_back(len[7:0]);
      end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", frame_err); else passes++;
    checks++; if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d expected 0", err_code); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (num_leds !== 12'd88) $display("FAIL reset_num_leds: got %0d expected 88", num_leds); else passes++;
    rst = 1'b0;
    model_nl = 12'd88;
    @(negedge clk);
  endtask

  task automatic test_pixel_frame();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h03};
    logic [7:0] ew[6] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    clear_obs();
    send_byte(f[0], 0);
    checks++; if (busy !== 1'b1) $display("FAIL pixel_busy_after_sync: got %b expected 1", busy); else passes++;
    for (int i = 1; i < f.size(); i++) send_byte(f[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() != 6) $display("FAIL pixel_wr_count: got %0d expected 6", got_wr.size()); else passes++;
    for (int i = 0; i < 6 && i < got_wr.size(); i++) begin
      checks++; if (got_wr[i] !== ew[i]) $display("FAIL pixel_wr_data[%0d]: got %02h expected %02h", i, got_wr[i], ew[i]); else passes++;
    end
    checks++; if (got_ev.size() != 1 || got_ev[0] != 4) $display("FAIL pixel_done: got %0d events (first %0d) expected one done", got_ev.size(), got_ev.size() > 0 ? got_ev[0] : -1); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL pixel_busy_after: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_config();
    logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h12};
    clear_obs();
    foreach (f[i]) send_byte(f[i], 1);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 1 || got_ev[0] != 4) $display("FAIL config_done: got %0d events expected one done", got_ev.size()); else passes++;
    checks++; if (got_nl.size() != 1 || got_nl[0] !== 12'd16) $display("FAIL config_nl_at_done: got %0d expected 16", got_nl.size() > 0 ? int'(got_nl[0]) : -1); else passes++;
    clear_obs();
    f[4] = 8'h13;
    f[3] = 8'h20;
    foreach (f[i]) send_byte(f[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 1 || got_ev[0] != 0) $display("FAIL config_bad_csum: got %0d events (first %0d) expected one err 0", got_ev.size(), got_ev.size() > 0 ? got_ev[0] : -1); else passes++;
    checks++; if (num_leds !== 12'd16) $display("FAIL config_nl_unchanged: got %0d expected 16", num_leds); else passes++;
    model_nl = 12'd16;
  endtask

  task automatic test_bad_header();
    logic [7:0] g[$] = '{8'h00, 8'h33, 8'hA5, 8'h07};
    logic [7:0] z[$] = '{8'hA5, 8'h01, 8'h00, 8'h00};
    logic [7:0] o[$] = '{8'hA5, 8'h01, 8'h00, 8'h11};
    logic [7:0] c[$] = '{8'hA5, 8'h02, 8'h00, 8'h00};
    clear_obs();
    foreach (g[i]) send_byte(g[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 1 || got_ev[0] != 1) $display("FAIL bad_cmd: got %0d events (first %0d) expected one err 1", got_ev.size(), got_ev.size() > 0 ? got_ev[0] : -1); else passes++;
    clear_obs();
    foreach (z[i]) send_byte(z[i], 0);
    foreach (o[i]) send_byte(o[i], 0);
    foreach (c[i]) send_byte(c[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 3 || got_ev[0] != 1 || got_ev[1] != 1 || got_ev[2] != 1)
      $display("FAIL bad_len: got %0d events expected three err 1 (len0, len>num_leds, cfg len0)", got_ev.size()); else passes++;
    checks++; if (err_code !== 2'd1) $display("FAIL bad_len_code_held: got %0d expected 1", err_code); else passes++;
  endtask

  task automatic test_fifo_full();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h03};
    clear_obs();
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    fifo_full = 1'b1;
    send_byte(f[6], 0);
    fifo_full = 1'b0;
    for (int i = 7; i < f.size(); i++) send_byte(f[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() != 2) $display("FAIL ovf_wr_count: got %0d expected 2", got_wr.size()); else passes++;
    checks++; if (got_ev.size() != 1 || got_ev[0] != 2) $display("FAIL ovf_err: got %0d events (first %0d) expected one err 2", got_ev.size(), got_ev.size() > 0 ? got_ev[0] : -1); else passes++;
    clear_obs();
    foreach (f[i]) send_byte(f[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 1 || got_ev[0] != 4 || got_wr.size() != 6) $display("FAIL ovf_recover: got %0d events, %0d writes expected done and 6", got_ev.size(), got_wr.size()); else passes++;
    checks++; if (err_code !== 2'd2) $display("FAIL ovf_code_held: got %0d expected 2", err_code); else passes++;
  endtask

  task automatic test_timeout();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hFF};
    int t0;
    bit seen = 0;
    clear_obs();
    foreach (f[i]) send_byte(f[i], 0);
    t0 = cyc;
    for (int k = 0; k < int'(TO) + 20 && !seen; k++) begin
      @(negedge clk);
      if (frame_err) seen = 1;
    end
    checks++; if (!seen || cyc - t0 != int'(TO)) $display("FAIL timeout_latency: got %0d cycles (seen=%0d) expected %0d", cyc - t0, seen, TO); else passes++;
    checks++; if (err_code !== 2'd3) $display("FAIL timeout_code: got %0d expected 3", err_code); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_byte_wins_timeout();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFF};
    clear_obs();
    foreach (f[i]) send_byte(f[i], (i >= 3) ? int'(TO) - 1 : 0);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 1 || got_ev[0] != 4 || got_wr.size() != 3) $display("FAIL byte_wins: got %0d events (first %0d), %0d writes expected done and 3", got_ev.size(), got_ev.size() > 0 ? got_ev[0] : -1, got_wr.size()); else passes++;
  endtask

  task automatic test_reset_mid_payload();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h03};
    clear_obs();
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL midrst_outputs: got busy=%b wr=%b done=%b err=%b expected all 0", busy, fifo_wr_en, frame_done, frame_err); else passes++;
    checks++; if (num_leds !== 12'd88 || err_code !== 2'd0) $display("FAIL midrst_regs: got num_leds=%0d err_code=%0d expected 88 and 0", num_leds, err_code); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_nl = 12'd88;
    @(negedge clk);
    clear_obs();
    foreach (f[i]) send_byte(f[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (got_ev.size() != 1 || got_ev[0] != 4 || got_wr.size() != 6) $display("FAIL midrst_recover: got %0d events, %0d writes expected done and 6", got_ev.size(), got_wr.size()); else passes++;
  endtask

  task automatic test_random(input int rounds, input int gapmax, input string tag);
    for (int r = 0; r < rounds; r++) begin
      stim.delete();
      clear_obs();
      for (int k = 0; k < 6; k++) gen_frame();
      model_stream();
      send_stim(gapmax);
      repeat (4) @(negedge clk);
      checks++; if (got_wr.size() != exp_wr.size()) $display("FAIL %s_wr_count[%0d]: got %0d expected %0d", tag, r, got_wr.size(), exp_wr.size()); else passes++;
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
        checks++; if (got_wr[i] !== exp_wr[i]) $display("FAIL %s_wr_data[%0d.%0d]: got %02h expected %02h", tag, r, i, got_wr[i], exp_wr[i]); else passes++;
      end
      checks++; if (got_ev.size() != exp_ev.size()) $display("FAIL %s_ev_count[%0d]: got %0d expected %0d", tag, r, got_ev.size(), exp_ev.size()); else passes++;
      for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
        checks++; if (got_ev[i] != exp_ev[i]) $display("FAIL %s_event[%0d.%0d]: got %0d expected %0d", tag, r, i, got_ev[i], exp_ev[i]); else passes++;
      end
      for (int i = 0; i < exp_nl.size() && i < got_nl.size(); i++) begin
        checks++; if (got_nl[i] !== exp_nl[i]) $display("FAIL %s_nl_at_done[%0d.%0d]: got %0d expected %0d", tag, r, i, got_nl[i], exp_nl[i]); else passes++;
      end
      checks++; if (num_leds !== model_nl || busy !== 1'b0) $display("FAIL %s_end_state[%0d]: got num_leds=%0d busy=%b expected %0d and 0", tag, r, num_leds, busy, model_nl); else passes++;
    end
  endtask

  initial begin
    #2;
    @(negedge clk);
    test_reset();
    test_pixel_frame();
    test_config();
    test_bad_header();
    test_fifo_full();
    test_timeout();
    test_byte_wins_timeout();
    test_reset_mid_payload();
    test_random(25, 3, "random");
    test_random(25, 0, "back_to_back");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
